// File: rtl/parking_lot_ctrl.sv
// Parking lot occupancy controller: one passage-detecting FSM per gate plus a shared clamped counter.
// Define PARKING_SYNC_EN to pass every outer/inner sensor bit through a 2-flop synchronizer.
module parking_lot_ctrl #(
    parameter int NUM_GATES = 2,
    parameter int CAPACITY  = 25,
    parameter int CNT_W     = $clog2(CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] outer,
    input  logic [NUM_GATES-1:0] inner,
    output logic [CNT_W-1:0]     count,
    output logic [NUM_GATES-1:0] enter,
    output logic [NUM_GATES-1:0] exit,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow
);

    typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3} state_t;

    localparam int PW = 3;          // popcount width, enough for up to 4 gates
    localparam int SW = CNT_W + 4;  // signed headroom for count + entries - exits

    logic [NUM_GATES-1:0] outer_s;
    logic [NUM_GATES-1:0] inner_s;

`ifdef PARKING_SYNC_EN
    logic [NUM_GATES-1:0] outer_meta_q, outer_meta_d, outer_sync_q, outer_sync_d;
    logic [NUM_GATES-1:0] inner_meta_q, inner_meta_d, inner_sync_q, inner_sync_d;

    always_comb begin
        outer_meta_d = outer;
        outer_sync_d = outer_meta_q;
        inner_meta_d = inner;
        inner_sync_d = inner_meta_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outer_meta_q <= '0;
            outer_sync_q <= '0;
            inner_meta_q <= '0;
            inner_sync_q <= '0;
        end else begin
            outer_meta_q <= outer_meta_d;
            outer_sync_q <= outer_sync_d;
            inner_meta_q <= inner_meta_d;
            inner_sync_q <= inner_sync_d;
        end
    end

    assign outer_s = outer_sync_q;
    assign inner_s = inner_sync_q;
`else
    assign outer_s = outer;
    assign inner_s = inner;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GATES; gi++) begin : g_gate
            state_t     state_q, state_d;
            logic       enter_q, enter_d;
            logic       exit_q, exit_d;
            logic [1:0] code;

            assign code = {outer_s[gi], inner_s[gi]};

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= IDLE;
                    enter_q <= 1'b0;
                    exit_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    enter_q <= enter_d;
                    exit_q  <= exit_d;
                end
            end

            // OUTx states mirror INx with the sensor roles swapped.
            always_comb begin
                state_d = IDLE;
                case (state_q)
                    IDLE: case (code)
                        2'b10:   state_d = IN1;
                        2'b01:   state_d = OUT1;
                        default: state_d = IDLE;
                    endcase
                    IN1: case (code)
                        2'b11:   state_d = IN2;
                        2'b10:   state_d = IN1;
                        default: state_d = IDLE;
                    endcase
                    IN2: case (code)
                        2'b01:   state_d = IN3;
                        2'b10:   state_d = IN1;
                        2'b11:   state_d = IN2;
                        default: state_d = IDLE;
                    endcase
                    IN3: case (code)
                        2'b11:   state_d = IN2;
                        2'b01:   state_d = IN3;
                        default: state_d = IDLE;
                    endcase
                    OUT1: case (code)
                        2'b11:   state_d = OUT2;
                        2'b01:   state_d = OUT1;
                        default: state_d = IDLE;
                    endcase
                    OUT2: case (code)
                        2'b10:   state_d = OUT3;
                        2'b01:   state_d = OUT1;
                        2'b11:   state_d = OUT2;
                        default: state_d = IDLE;
                    endcase
                    OUT3: case (code)
                        2'b11:   state_d = OUT2;
                        2'b10:   state_d = OUT3;
                        default: state_d = IDLE;
                    endcase
                    default: state_d = IDLE;
                endcase
            end

            always_comb begin
                enter_d = (state_q == IN3)  && (code == 2'b00);
                exit_d  = (state_q == OUT3) && (code == 2'b00);
            end

            assign enter[gi] = enter_q;
            assign exit[gi]  = exit_q;
        end
    endgenerate

    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic [PW-1:0]        n_enter, n_exit;
    logic signed [SW-1:0] net;

    // Entries and exits of the same cycle net out first; only the net result is clamped.
    always_comb begin
        n_enter = '0;
        n_exit  = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            n_enter = n_enter + PW'(enter[g]);
            n_exit  = n_exit + PW'(exit[g]);
        end
        net = $signed(SW'(count_q)) + $signed(SW'(n_enter)) - $signed(SW'(n_exit));
        count_d     = net[CNT_W-1:0];
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (net > $signed(SW'(CAPACITY))) begin
            count_d    = CNT_W'(CAPACITY);
            overflow_d = 1'b1;
        end else if (net[SW-1]) begin
            count_d     = '0;
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign full      = (count_q == CNT_W'(CAPACITY));
    assign empty     = (count_q == '0);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed scoreboard bench for parking_lot_ctrl: each passage pushes its expected outcome, popped once it has settled.
module tb_parking_lot_ctrl;
    localparam int NG  = 2;
    localparam int CAP = 25;
    localparam int CW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NG-1:0] outer, inner;
    logic [CW-1:0] count;
    logic [NG-1:0] enter, exit;
    logic          full, empty, overflow, underflow;

    always #5 clk = ~clk;

    parking_lot_ctrl #(.NUM_GATES(NG), .CAPACITY(CAP), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .outer(outer), .inner(inner),
        .count(count), .enter(enter), .exit(exit), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    // Pulse monitor: counts cycles each enter/exit bit is high.
    int ent_cnt [NG];
    int ext_cnt [NG];
    always @(negedge clk) begin
        for (int g = 0; g < NG; g++) begin
            if (enter[g] === 1'b1) ent_cnt[g]++;
            if (exit[g] === 1'b1)  ext_cnt[g]++;
        end
    end

    typedef struct {
        string         tag;
        logic [NG-1:0] e;
        logic [NG-1:0] x;
        int            cnt;
        logic          ovf;
        logic          unf;
    } exp_t;
    exp_t sbq[$];

    int   m_cnt;
    logic m_ovf, m_unf;
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [7:0] ENT  = 8'b10_11_01_00;
    localparam logic [7:0] BACK = 8'b10_11_10_00;
    localparam logic [7:0] LONE = 8'b01_00_00_00;

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [NG-1:0] o, input logic [NG-1:0] i, input int n);
        outer = o;
        inner = i;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_static(input string tag);
        cmp({tag, " count"}, 32'(count), 32'(m_cnt));
        cmp({tag, " full"}, 32'(full), 32'(m_cnt == CAP));
        cmp({tag, " empty"}, 32'(empty), 32'(m_cnt == 0));
        cmp({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        cmp({tag, " underflow"}, 32'(underflow), 32'(m_unf));
        cmp({tag, " enter"}, 32'(enter), 32'd0);
        cmp({tag, " exit"}, 32'(exit), 32'd0);
        $display("state %s: count=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                 tag, count, full, empty, overflow, underflow);
    endtask

    // ge gates walk codes as an entry, gx gates walk the same codes with sensors swapped (exit).
    task automatic txn(input string tag, input logic [NG-1:0] ge, input logic [NG-1:0] gx,
                       input logic [7:0] codes, input logic [NG-1:0] ee, input logic [NG-1:0] ex);
        exp_t          t;
        int            net;
        int            s_e [NG];
        int            s_x [NG];
        logic [1:0]    p;
        logic [NG-1:0] o, i;
        net = m_cnt + $countones(ee) - $countones(ex);
        if (net > CAP) begin
            m_cnt = CAP;
            m_ovf = 1'b1;
        end else if (net < 0) begin
            m_cnt = 0;
            m_unf = 1'b1;
        end else begin
            m_cnt = net;
        end
        t.tag = tag; t.e = ee; t.x = ex; t.cnt = m_cnt; t.ovf = m_ovf; t.unf = m_unf;
        sbq.push_back(t);
        for (int g = 0; g < NG; g++) begin
            s_e[g] = ent_cnt[g];
            s_x[g] = ext_cnt[g];
        end
        for (int k = 0; k < 4; k++) begin
            p = codes[7-2*k -: 2];
            o = '0;
            i = '0;
            for (int g = 0; g < NG; g++) begin
                if (ge[g]) begin o[g] = p[1]; i[g] = p[0]; end
                if (gx[g]) begin o[g] = p[0]; i[g] = p[1]; end
            end
            drive(o, i, 3);
        end
        drive('0, '0, 4);
        t = sbq.pop_front();
        for (int g = 0; g < NG; g++) begin
            cmp($sformatf("%s enter[%0d] pulses", t.tag, g), 32'(ent_cnt[g] - s_e[g]), 32'(t.e[g]));
            cmp($sformatf("%s exit[%0d] pulses", t.tag, g), 32'(ext_cnt[g] - s_x[g]), 32'(t.x[g]));
        end
        cmp({t.tag, " count"}, 32'(count), 32'(t.cnt));
        cmp({t.tag, " full"}, 32'(full), 32'(t.cnt == CAP));
        cmp({t.tag, " empty"}, 32'(empty), 32'(t.cnt == 0));
        cmp({t.tag, " overflow"}, 32'(overflow), 32'(t.ovf));
        cmp({t.tag, " underflow"}, 32'(underflow), 32'(t.unf));
        $display("txn %s: count=%0d exp=%0d ovf=%0b unf=%0b", t.tag, count, t.cnt, overflow, underflow);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        outer = '0;
        inner = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_static("reset");
        reset = 1'b1;
        drive('0, '0, 2);

        txn("entry g0", 2'b01, 2'b00, ENT, 2'b01, 2'b00);
        txn("entry g1", 2'b10, 2'b00, ENT, 2'b10, 2'b00);
        txn("entry g0 again", 2'b01, 2'b00, ENT, 2'b01, 2'b00);
        txn("exit g1", 2'b00, 2'b10, ENT, 2'b00, 2'b10);
        txn("backout g0", 2'b01, 2'b00, BACK, 2'b00, 2'b00);
        txn("dual entry a", 2'b11, 2'b00, ENT, 2'b11, 2'b00);
        txn("dual entry b", 2'b11, 2'b00, ENT, 2'b11, 2'b00);
        txn("entry g1 to 7", 2'b10, 2'b00, ENT, 2'b10, 2'b00);

        // Park gate 0 in IN2, then pull reset asynchronously mid-cycle.
        drive(2'b01, 2'b00, 3);
        drive(2'b01, 2'b01, 3);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_static("async reset mid-passage");
        outer = '0;
        inner = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        txn("post-reset lone 01,00", 2'b01, 2'b00, LONE, 2'b00, 2'b00);

        txn("exit at empty", 2'b00, 2'b10, ENT, 2'b00, 2'b10);
        txn("entry keeps underflow", 2'b01, 2'b00, ENT, 2'b01, 2'b00);

        reset = 1'b0;
        #1;
        model_reset();
        check_static("reset clears flags");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        txn("entry+exit at empty", 2'b01, 2'b10, ENT, 2'b01, 2'b10);
        for (int n = 0; n < 12; n++) txn("fill dual", 2'b11, 2'b00, ENT, 2'b11, 2'b00);
        txn("fill to capacity", 2'b01, 2'b00, ENT, 2'b01, 2'b00);
        txn("entry+exit at full", 2'b01, 2'b10, ENT, 2'b01, 2'b10);
        txn("entry at full", 2'b01, 2'b00, ENT, 2'b01, 2'b00);
        txn("backout overflow sticky", 2'b01, 2'b00, BACK, 2'b00, 2'b00);
        txn("exit from full", 2'b00, 2'b10, ENT, 2'b00, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
